// File: rtl/mem_access_unit_if.sv
// Request/response and memory bus bundle for mem_access_unit.
// master = CPU datapath plus memory side, slave = the access unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  memRead, memWrite, address, WriteData,
    output ReadData
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output memRead, memWrite, address, WriteData,
    input  ReadData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-wide memory: byte/half/word accesses with
// sign/zero extension, read-modify-write for sub-word stores, error rejection.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

  state_t            state_reg;
  state_t            state_next;

  logic              write_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       write_data_reg;
  logic [31:0]       rdata_reg;

  logic              accept;
  logic              misalign;
  logic              range_err;
  logic              req_err;
  logic [31:0]       wdata_rep;
  logic [3:0]        lane_en;
  logic [31:0]       merged;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;

  assign accept = bus.req_valid && (state_reg == IDLE);

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = (bus.req_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  assign range_err = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
  assign req_err   = misalign || range_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next = ERR;
          end else if (bus.req_write && (bus.req_size == 2'b10)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = write_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store data replicated into every lane; lane_en then picks which lanes win.
  always_comb begin
    wdata_rep = write_data_reg;
    case (size_reg)
      2'b00:   wdata_rep = {4{write_data_reg[7:0]}};
      2'b01:   wdata_rep = {2{write_data_reg[15:0]}};
      default: wdata_rep = write_data_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = (size_reg == 2'b00) ? (lane_reg == 2'(gi)) :
                           (size_reg == 2'b01) ? (lane_reg[1] == 1'(gi >> 1)) :
                                                 1'b1;
      assign merged[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8]
                                             : bus.ReadData[8*gi +: 8];
    end
  endgenerate

  // Request latch and read-modify-write data path
  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      lane_reg       <= 2'b00;
      addr_reg       <= '0;
      write_data_reg <= 32'h0;
      rdata_reg      <= 32'h0;
    end else begin
      if (accept) begin
        write_reg      <= bus.req_write;
        size_reg       <= bus.req_size;
        signed_reg     <= bus.req_signed;
        lane_reg       <= bus.req_addr[1:0];
        addr_reg       <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        write_data_reg <= bus.req_wdata;
      end
      if (state_reg == RD) begin
        rdata_reg <= bus.ReadData;
        if (write_reg) begin
          write_data_reg <= merged;
        end
      end
    end
  end

  assign ld_byte = rdata_reg[{lane_reg, 3'b000} +: 8];
  assign ld_half = rdata_reg[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata_reg;
    case (size_reg)
      2'b00:   load_data = {{24{signed_reg & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{signed_reg & ld_half[15]}}, ld_half};
      default: load_data = rdata_reg;
    endcase
  end

  // Output decode; strobes are gated by rst so a reset cycle never writes.
  always_comb begin
    bus.req_ready  = (state_reg == IDLE);
    bus.memRead    = (state_reg == RD) && !rst;
    bus.memWrite   = (state_reg == WR) && !rst;
    bus.resp_valid = (state_reg == RESP) || (state_reg == ERR);
    bus.resp_err   = (state_reg == ERR);
    bus.resp_rdata = ((state_reg == RESP) && !write_reg) ? load_data : 32'h0;
    bus.address    = addr_reg;
    bus.WriteData  = write_data_reg;
  end

endmodule
